vcd_change_serializer: RTL and testbench

//  Snapshots NUM_SIG wide signals on a sample strobe and detects which changed since the last dump.

---
 rtl/vcd_change_serializer.sv | 159 +++++++++++++++
 tb/tb_vcd_change_serializer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/vcd_change_serializer.sv
// Snapshots NUM_SIG wide signals on a sample strobe and streams every changed signal,
// lowest id first, as one timestamp header beat followed by MSB-first CHUNK_W data beats.
module vcd_change_serializer #(
  parameter int NUM_SIG = 3,
  parameter int SIG_W   = 128,
  parameter int CHUNK_W = 32,
  parameter int TIME_W  = 32,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sample_i,
  input  logic [TIME_W-1:0]        time_i,
  input  logic [NUM_SIG*SIG_W-1:0] sig_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CHUNK_W-1:0]       out_data,
  output logic                     out_first,
  output logic                     out_last,
  output logic [ID_W-1:0]          out_id,
  output logic                     busy_o,
  output logic                     overrun_o,
  input  logic                     clr_overrun
);
  localparam int NBEAT  = (SIG_W + CHUNK_W - 1) / CHUNK_W;
  localparam int PAD_W  = NBEAT * CHUNK_W;
  localparam int BEAT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;

  // CMP compares the fresh snapshot against the last dumped values before scheduling.
  typedef enum logic [2:0] {IDLE, CMP, SCAN, HDR, DATA} state_t;

  state_t             state, state_next;
  logic [SIG_W-1:0]   snap [NUM_SIG];
  logic [SIG_W-1:0]   prev [NUM_SIG];
  logic [NUM_SIG-1:0] pending, changed;
  logic               first_f;
  logic [TIME_W-1:0]  t;
  logic [ID_W-1:0]    id, low_id;
  logic [BEAT_W-1:0]  beat;
  logic               last_beat;
  logic [PAD_W-1:0]   cur;
  logic [CHUNK_W-1:0] chunk, t_chunk;

  generate
    if (TIME_W >= CHUNK_W) begin : g_time_trunc
      assign t_chunk = t[CHUNK_W-1:0];
    end else begin : g_time_ext
      assign t_chunk = {{(CHUNK_W-TIME_W){1'b0}}, t};
    end
  endgenerate

  assign last_beat = (beat == BEAT_W'(NBEAT - 1));
  assign busy_o    = (state != IDLE);

  always_comb begin
    changed = '0;
    low_id  = '0;
    for (int k = 0; k < NUM_SIG; k++) begin
      changed[k] = first_f | (snap[k] != prev[k]);
    end
    for (int k = NUM_SIG - 1; k >= 0; k--) begin
      if (pending[k]) low_id = ID_W'(k);
    end
  end

  // Current signal zero-padded to a whole number of chunks, then the beat's chunk picked MSB first.
  always_comb begin
    cur   = '0;
    chunk = '0;
    for (int k = 0; k < NUM_SIG; k++) begin
      if (id == ID_W'(k)) cur[SIG_W-1:0] = snap[k];
    end
    for (int j = 0; j < NBEAT; j++) begin
      if (beat == BEAT_W'(j)) chunk = cur[(NBEAT-1-j)*CHUNK_W +: CHUNK_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    out_first  = 1'b0;
    out_last   = 1'b0;
    out_data   = '0;
    out_id     = '0;
    case (state)
      IDLE: if (sample_i) state_next = CMP;
      CMP:  state_next = SCAN;
      SCAN: state_next = (pending == '0) ? IDLE : HDR;
      HDR: begin
        out_valid = 1'b1;
        out_first = 1'b1;
        out_id    = id;
        out_data  = t_chunk;
        if (out_ready) state_next = DATA;
      end
      DATA: begin
        out_valid = 1'b1;
        out_id    = id;
        out_data  = chunk;
        out_last  = last_beat;
        if (out_ready && last_beat) state_next = SCAN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_SIG; k++) begin
        snap[k] <= '0;
        prev[k] <= '0;
      end
      pending   <= '0;
      first_f   <= 1'b1;
      t         <= '0;
      id        <= '0;
      beat      <= '0;
      overrun_o <= 1'b0;
    end else begin
      if (sample_i && state != IDLE) overrun_o <= 1'b1;
      else if (clr_overrun)          overrun_o <= 1'b0;

      case (state)
        IDLE: begin
          if (sample_i) begin
            for (int k = 0; k < NUM_SIG; k++) snap[k] <= sig_i[k*SIG_W +: SIG_W];
            t <= time_i;
          end
        end
        CMP: begin
          pending <= changed;
          first_f <= 1'b0;
        end
        SCAN: id <= low_id;
        HDR:  if (out_ready) beat <= '0;
        DATA: begin
          if (out_ready) begin
            if (last_beat) begin
              for (int k = 0; k < NUM_SIG; k++) begin
                if (id == ID_W'(k)) begin
                  prev[k]    <= snap[k];
                  pending[k] <= 1'b0;
                end
              end
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_vcd_change_serializer.sv
// Directed plus randomized bench for vcd_change_serializer; expected streams come from a
// per-sample model (changed list, header, MSB-first chunks) compared against captured beats.
module tb_vcd_change_serializer;
  localparam int NS = 3, SW = 128, CW = 32, TW = 32, IW = 2;
  localparam int NB = (SW + CW - 1) / CW;

  typedef struct packed {
    logic [CW-1:0] data;
    logic          first;
    logic          last;
    logic [IW-1:0] id;
  } beat_t;

  logic             clk = 0, rst_n = 0, sample_i = 0, out_ready = 1, clr_overrun = 0;
  logic [TW-1:0]    time_i = '0;
  logic [NS*SW-1:0] sig_i = '0;
  logic             out_valid, out_first, out_last, busy_o, overrun_o;
  logic [CW-1:0]    out_data;
  logic [IW-1:0]    out_id;

  int tests = 0, fails = 0;
  beat_t got[$], exp_q[$];
  logic [SW-1:0] m_prev [NS];
  bit m_first = 1;
  bit rand_ready = 0;
  bit stalled = 0;
  beat_t held, cur_b;

  vcd_change_serializer #(.NUM_SIG(NS), .SIG_W(SW), .CHUNK_W(CW), .TIME_W(TW), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .sample_i(sample_i), .time_i(time_i), .sig_i(sig_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_first(out_first),
    .out_last(out_last), .out_id(out_id), .busy_o(busy_o), .overrun_o(overrun_o),
    .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Mid-cycle monitor: records transfers and checks that stalled beats hold still.
  always @(negedge clk) begin
    cur_b = '{data: out_data, first: out_first, last: out_last, id: out_id};
    if (!rst_n) begin
      stalled = 0;
    end else begin
      if (stalled) chk("stall_hold", {out_valid, cur_b}, {1'b1, held});
      if (out_valid && out_ready) got.push_back(cur_b);
      stalled = out_valid && !out_ready;
      held = cur_b;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic model_sample(input logic [NS*SW-1:0] s, input logic [TW-1:0] tm);
    logic [SW-1:0] v;
    for (int k = 0; k < NS; k++) begin
      v = s[k*SW +: SW];
      if (m_first || v != m_prev[k]) begin
        exp_q.push_back('{data: CW'(tm), first: 1'b1, last: 1'b0, id: IW'(k)});
        for (int b = 0; b < NB; b++)
          exp_q.push_back('{data: CW'(v >> ((NB - 1 - b) * CW)), first: 1'b0,
                            last: (b == NB - 1), id: IW'(k)});
        m_prev[k] = v;
      end
    end
    m_first = 0;
  endtask

  task automatic do_sample(input logic [NS*SW-1:0] s, input logic [TW-1:0] tm);
    sig_i = s; time_i = tm; sample_i = 1;
    model_sample(s, tm);
    step();
    sample_i = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 2000) begin step(); n++; end
    chk("idle_timeout", busy_o, 1'b0);
    rand_ready = 0; out_ready = 1;
    step();
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk({tag, "_beat"}, got[i], exp_q[i]);
    $display("[TB] %s: %0d beats captured, %0d expected", tag, got.size(), exp_q.size());
    got.delete(); exp_q.delete();
  endtask

  logic [NS*SW-1:0] base, s2;
  int n, bc;

  initial begin
    for (int k = 0; k < NS; k++) m_prev[k] = '0;
    repeat (3) step();
    chk("rst_valid", out_valid, 0); chk("rst_busy", busy_o, 0); chk("rst_ovr", overrun_o, 0);
    chk("rst_outs", {out_data, out_id, out_first, out_last}, '0);
    rst_n = 1;
    step();

    // 1: first sample dumps everything; header valid two edges after the sample edge
    base = '0;
    base[0*SW +: SW] = 128'hDEADBEEF;
    base[1*SW +: SW] = 128'hCAFEBABE_DEADBEEF;
    base[2*SW +: SW] = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    do_sample(base, 32'd5);
    chk("lat_cmp", out_valid, 0);
    step();
    chk("lat_scan", out_valid, 0);
    step();
    chk("lat_hdr", {out_valid, out_first, out_data}, {1'b1, 1'b1, 32'd5});
    wait_idle();
    chk("t1_size", got.size(), 15);
    if (got.size() == 15) begin
      chk("t1_sig0", got[4].data, 32'hDEADBEEF);
      chk("t1_sig2_b0", got[11].data, 32'h01234567);
      chk("t1_sig2_b1", got[12].data, 32'h89ABCDEF);
      chk("t1_sig2_b2", got[13].data, 32'hFEDCBA98);
      chk("t1_sig2_b3", {got[14].data, got[14].last}, {32'h76543210, 1'b1});
    end
    check_stream("t1");

    // 2: only sig1 changes
    base[1*SW +: SW] = base[1*SW +: SW] + 128'h11111111_11111111;
    do_sample(base, 32'd9);
    wait_idle();
    check_stream("t2");

    // 3: no change, busy for exactly CMP + SCAN
    do_sample(base, 32'd12);
    bc = 1;
    while (busy_o && bc < 50) begin step(); bc++; end
    chk("t3_busy_cycles", bc - 1, 2);
    wait_idle();
    check_stream("t3");

    // 4: backpressure for three cycles mid-signal
    base[0*SW +: SW] = 128'h12345678_9ABCDEF0;
    base[2*SW +: SW] = ~base[2*SW +: SW];
    do_sample(base, 32'd20);
    n = 0;
    while (got.size() < 3 && n < 100) begin step(); n++; end
    out_ready = 0;
    repeat (3) step();
    out_ready = 1;
    wait_idle();
    check_stream("t4");

    // 5: overrun is sticky, ignored sample leaves the snapshot alone
    base[1*SW +: SW] = 128'h55;
    do_sample(base, 32'd30);
    step();
    s2 = ~base;
    sig_i = s2; sample_i = 1;
    step();
    sample_i = 0; sig_i = base;
    chk("t5_ovr_set", overrun_o, 1);
    wait_idle();
    check_stream("t5a");
    do_sample(base, 32'd40);
    wait_idle();
    check_stream("t5_nochange");
    clr_overrun = 1; step(); clr_overrun = 0;
    chk("t5_ovr_clr", overrun_o, 0);
    base[0*SW +: SW] = 128'h77;
    do_sample(base, 32'd50);
    step();
    sample_i = 1; clr_overrun = 1;
    step();
    sample_i = 0; clr_overrun = 0;
    chk("t5_set_wins", overrun_o, 1);
    wait_idle();
    check_stream("t5b");
    clr_overrun = 1; step(); clr_overrun = 0;

    // 6: async reset during DATA beat 2, then full re-dump
    base[2*SW +: SW] = 128'hABCD;
    do_sample(base, 32'd60);
    n = 0;
    while (got.size() < 3 && n < 100) begin step(); n++; end
    #2 rst_n = 0;
    #1;
    chk("t6_rst_outs", {out_valid, out_first, out_last, busy_o, overrun_o, out_id, out_data}, '0);
    got.delete(); exp_q.delete();
    m_first = 1;
    for (int k = 0; k < NS; k++) m_prev[k] = '0;
    step();
    rst_n = 1;
    step();
    do_sample(base, 32'd70);
    wait_idle();
    check_stream("t6_redump");

    // Randomized changes and ready pattern
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < NS; k++)
        if ($urandom_range(0, 1) == 1) base[k*SW +: SW] = {$urandom, $urandom, $urandom, $urandom};
      rand_ready = 1;
      do_sample(base, $urandom);
      wait_idle();
      check_stream($sformatf("rand%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
